// File: rtl/prog_ram_pkg.sv
// ============================================================================
// Module      : prog_ram_pkg
// Description : Shared types and constants for the switch-programmable
//               program RAM loader (including the demo preload image).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_ram_pkg;

    typedef enum logic [1:0] {
        LOAD_HI = 2'd0,
        LOAD_LO = 2'd1,
        RUN     = 2'd2
    } loader_state_t;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] instr_t;

    localparam int PROG_DEPTH = 16;

    localparam instr_t PRELOAD_IMAGE [PROG_DEPTH] = '{
        8'hBC, 8'h43, 8'h90, 8'h86, 8'hA0, 8'h1C, 8'h90, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // First free slot after the demo program
    localparam nibble_t PRELOAD_NEXT_ADDR = 4'd7;

endpackage

`default_nettype wire

// File: rtl/prog_ram_if.sv
// ============================================================================
// Module      : prog_ram_if
// Description : CPU-side instruction fetch port of the program RAM loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_ram_if;
    import prog_ram_pkg::*;

    nibble_t cpu_addr;
    instr_t  cpu_data;
    logic    cpu_hold;

    modport master (output cpu_addr, input  cpu_data, input  cpu_hold);
    modport slave  (input  cpu_addr, output cpu_data, output cpu_hold);

endinterface

`default_nettype wire

// File: rtl/prog_ram_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Synchroniser chain followed by a stable-level debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 240000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  wire logic pin_clock,
    input  wire logic pin_n_reset,
    input  wire logic raw_i,
    output logic      level_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   w_sample;

    assign w_sample = sync_q[SYNC_STAGES-1];
    assign level_o  = level_q;

    always_ff @(posedge pin_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            // Any return to the accepted level restarts the stability window
            if (w_sample == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= w_sample;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_ram_loader.sv
// ============================================================================
// Module      : prog_ram_loader
// Description : 16x8 program RAM entered nibble-by-nibble from switches,
//               served to the CPU in RUN mode. Macro PROG_RAM_PRELOAD_EN
//               selects the demo program as reset contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram_loader
    import prog_ram_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int SYNC_STAGES     = 2
) (
    input  wire logic    pin_clock,
    input  wire logic    pin_n_reset,
    input  wire nibble_t pin_switch,
    input  wire logic    pin_n_write,
    input  wire logic    pin_run,
    prog_ram_if.slave    cpu,
    output nibble_t      load_addr,
    output nibble_t      disp_nibble
);

`ifdef PROG_RAM_PRELOAD_EN
    localparam instr_t  RESET_IMAGE [PROG_DEPTH] = PRELOAD_IMAGE;
    localparam nibble_t RESET_ADDR = PRELOAD_NEXT_ADDR;
`else
    localparam instr_t  RESET_IMAGE [PROG_DEPTH] = '{default: 8'h00};
    localparam nibble_t RESET_ADDR = 4'd0;
`endif

    logic          w_wr_lvl, w_run_lvl, w_wr_pulse, w_mem_we;
    logic          wr_prev_q;
    nibble_t       sw_sync_q [SYNC_STAGES];
    nibble_t       w_sw;
    loader_state_t state_q, state_d;
    nibble_t       load_addr_q, load_addr_d;
    nibble_t       hi_nib_q, hi_nib_d;
    logic          hold_q;
    instr_t        mem_q [PROG_DEPTH];

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)
    ) u_write_db (
        .pin_clock(pin_clock), .pin_n_reset(pin_n_reset), .raw_i(pin_n_write), .level_o(w_wr_lvl)
    );

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)
    ) u_run_db (
        .pin_clock(pin_clock), .pin_n_reset(pin_n_reset), .raw_i(pin_run), .level_o(w_run_lvl)
    );

    assign w_wr_pulse = wr_prev_q & ~w_wr_lvl;
    assign w_sw       = sw_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        hi_nib_d    = hi_nib_q;
        w_mem_we    = 1'b0;
        case (state_q)
            LOAD_HI: begin
                if (w_run_lvl) begin
                    state_d = RUN;
                end else if (w_wr_pulse) begin
                    hi_nib_d = w_sw;
                    state_d  = LOAD_LO;
                end
            end
            LOAD_LO: begin
                // Run wins over a coincident press; the pending high nibble is dropped
                if (w_run_lvl) begin
                    state_d = RUN;
                end else if (w_wr_pulse) begin
                    w_mem_we    = 1'b1;
                    load_addr_d = load_addr_q + 4'd1;
                    state_d     = LOAD_HI;
                end
            end
            RUN: begin
                if (!w_run_lvl) begin
                    state_d     = LOAD_HI;
                    load_addr_d = 4'd0;
                end
            end
            default: state_d = LOAD_HI;
        endcase
    end

    always_ff @(posedge pin_clock or negedge pin_n_reset) begin
        if (!pin_n_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= 4'd0;
            for (int i = 0; i < PROG_DEPTH; i++)  mem_q[i]     <= RESET_IMAGE[i];
            wr_prev_q   <= 1'b1;
            state_q     <= LOAD_HI;
            load_addr_q <= RESET_ADDR;
            hi_nib_q    <= 4'd0;
            hold_q      <= 1'b1;
        end else begin
            sw_sync_q[0] <= pin_switch;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
            if (w_mem_we) mem_q[load_addr_q] <= {hi_nib_q, w_sw};
            wr_prev_q   <= w_wr_lvl;
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            hi_nib_q    <= hi_nib_d;
            hold_q      <= (state_d != RUN);
        end
    end

    always_comb begin
        case (state_q)
            LOAD_HI: disp_nibble = load_addr_q;
            LOAD_LO: disp_nibble = hi_nib_q;
            default: disp_nibble = 4'd0;
        endcase
    end

    assign load_addr    = load_addr_q;
    assign cpu.cpu_hold = hold_q;
    assign cpu.cpu_data = mem_q[cpu.cpu_addr];

endmodule

`default_nettype wire

// File: tb/tb_prog_ram_loader.sv
// ============================================================================
// Module      : tb_prog_ram_loader
// Description : Directed self-checking bench for prog_ram_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_ram_loader;

    logic       pin_clock;
    logic       pin_n_reset;
    logic [3:0] pin_switch;
    logic       pin_n_write;
    logic       pin_run;
    logic [3:0] load_addr;
    logic [3:0] disp_nibble;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_img [16];
    logic [3:0] exp_reset_addr;

    prog_ram_if cpu_bus ();

    prog_ram_loader #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .pin_clock(pin_clock), .pin_n_reset(pin_n_reset), .pin_switch(pin_switch),
        .pin_n_write(pin_n_write), .pin_run(pin_run), .cpu(cpu_bus),
        .load_addr(load_addr), .disp_nibble(disp_nibble)
    );

    initial pin_clock = 1'b0;
    always #5 pin_clock = ~pin_clock;

    task automatic tick(input int n);
        repeat (n) @(negedge pin_clock);
    endtask

    task automatic press(input logic [3:0] nib);
        pin_switch  = nib;
        pin_n_write = 1'b0;
        tick(12);
        pin_n_write = 1'b1;
        tick(12);
    endtask

    task automatic set_run(input logic v);
        pin_run = v;
        tick(12);
    endtask

    task automatic do_reset;
        pin_n_write = 1'b1;
        pin_run     = 1'b0;
        pin_n_reset = 1'b0;
        tick(3);
        pin_n_reset = 1'b1;
        tick(2);
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++; if (cpu_bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b exp 1", cpu_bus.cpu_hold); end
        n_checks++; if (load_addr !== exp_reset_addr) begin n_fail++; $display("FAIL reset_addr got %h exp %h", load_addr, exp_reset_addr); end
        n_checks++; if (disp_nibble !== exp_reset_addr) begin n_fail++; $display("FAIL reset_disp got %h exp %h", disp_nibble, exp_reset_addr); end
        for (int a = 0; a < 16; a++) begin
            cpu_bus.cpu_addr = 4'(a);
            #1;
            n_checks++;
            if (cpu_bus.cpu_data !== exp_img[a]) begin
                n_fail++; $display("FAIL reset_mem[%0d] got %h exp %h", a, cpu_bus.cpu_data, exp_img[a]);
            end
        end
    endtask

    task automatic test_basic_entry;
        do_reset();
        cpu_bus.cpu_addr = 4'd0;
        press(4'hB);
        n_checks++; if (disp_nibble !== 4'hB) begin n_fail++; $display("FAIL basic_disp_hi got %h exp b", disp_nibble); end
        n_checks++; if (load_addr !== 4'd0) begin n_fail++; $display("FAIL basic_addr_hi got %h exp 0", load_addr); end
        press(4'hC);
        n_checks++; if (load_addr !== 4'd1) begin n_fail++; $display("FAIL basic_addr got %h exp 1", load_addr); end
        n_checks++; if (disp_nibble !== 4'd1) begin n_fail++; $display("FAIL basic_disp got %h exp 1", disp_nibble); end
        n_checks++; if (cpu_bus.cpu_data !== 8'hBC) begin n_fail++; $display("FAIL basic_data_load got %h exp bc", cpu_bus.cpu_data); end
        set_run(1'b1);
        n_checks++; if (cpu_bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold_run got %b exp 0", cpu_bus.cpu_hold); end
        n_checks++; if (disp_nibble !== 4'd0) begin n_fail++; $display("FAIL basic_disp_run got %h exp 0", disp_nibble); end
        n_checks++; if (cpu_bus.cpu_data !== 8'hBC) begin n_fail++; $display("FAIL basic_data_run got %h exp bc", cpu_bus.cpu_data); end
        set_run(1'b0);
        n_checks++; if (cpu_bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL basic_hold_load got %b exp 1", cpu_bus.cpu_hold); end
    endtask

    task automatic test_bounce;
        do_reset();
        cpu_bus.cpu_addr = 4'd0;
        pin_switch = 4'h3;
        for (int k = 0; k < 5; k++) begin
            pin_n_write = (k % 2 == 1);
            tick(2);
        end
        pin_n_write = 1'b0;
        tick(12);
        pin_n_write = 1'b1;
        tick(12);
        n_checks++; if (disp_nibble !== 4'h3) begin n_fail++; $display("FAIL bounce_disp got %h exp 3", disp_nibble); end
        n_checks++; if (load_addr !== 4'd0) begin n_fail++; $display("FAIL bounce_addr got %h exp 0", load_addr); end
        press(4'h4);
        n_checks++; if (cpu_bus.cpu_data !== 8'h34) begin n_fail++; $display("FAIL bounce_data got %h exp 34", cpu_bus.cpu_data); end
        n_checks++; if (load_addr !== 4'd1) begin n_fail++; $display("FAIL bounce_addr2 got %h exp 1", load_addr); end
    endtask

    task automatic test_wrap;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press(4'(i));
            press(~4'(i));
        end
        n_checks++; if (load_addr !== 4'd0) begin n_fail++; $display("FAIL wrap_addr0 got %h exp 0", load_addr); end
        cpu_bus.cpu_addr = 4'd5; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h5A) begin n_fail++; $display("FAIL wrap_mem5 got %h exp 5a", cpu_bus.cpu_data); end
        cpu_bus.cpu_addr = 4'd15; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'hF0) begin n_fail++; $display("FAIL wrap_mem15 got %h exp f0", cpu_bus.cpu_data); end
        press(4'h7);
        press(4'h7);
        n_checks++; if (load_addr !== 4'd1) begin n_fail++; $display("FAIL wrap_addr1 got %h exp 1", load_addr); end
        cpu_bus.cpu_addr = 4'd0; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h77) begin n_fail++; $display("FAIL wrap_mem0 got %h exp 77", cpu_bus.cpu_data); end
        cpu_bus.cpu_addr = 4'd1; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h1E) begin n_fail++; $display("FAIL wrap_mem1 got %h exp 1e", cpu_bus.cpu_data); end
    endtask

    task automatic test_run_abort;
        press(4'h5);
        n_checks++; if (disp_nibble !== 4'h5) begin n_fail++; $display("FAIL abort_disp_hi got %h exp 5", disp_nibble); end
        set_run(1'b1);
        n_checks++; if (cpu_bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL abort_hold got %b exp 0", cpu_bus.cpu_hold); end
        n_checks++; if (disp_nibble !== 4'd0) begin n_fail++; $display("FAIL abort_disp_run got %h exp 0", disp_nibble); end
        press(4'h9);
        cpu_bus.cpu_addr = 4'd1; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h1E) begin n_fail++; $display("FAIL abort_mem1 got %h exp 1e", cpu_bus.cpu_data); end
        cpu_bus.cpu_addr = 4'd2; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h2D) begin n_fail++; $display("FAIL abort_mem2 got %h exp 2d", cpu_bus.cpu_data); end
        n_checks++; if (load_addr !== 4'd1) begin n_fail++; $display("FAIL abort_addr_run got %h exp 1", load_addr); end
        set_run(1'b0);
        n_checks++; if (cpu_bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL abort_hold_load got %b exp 1", cpu_bus.cpu_hold); end
        n_checks++; if (load_addr !== 4'd0) begin n_fail++; $display("FAIL abort_addr got %h exp 0", load_addr); end
        n_checks++; if (disp_nibble !== 4'd0) begin n_fail++; $display("FAIL abort_disp got %h exp 0", disp_nibble); end
        press(4'h6);
        n_checks++; if (disp_nibble !== 4'h6) begin n_fail++; $display("FAIL abort_state_hi got %h exp 6", disp_nibble); end
        press(4'h2);
        cpu_bus.cpu_addr = 4'd0; #1;
        n_checks++; if (cpu_bus.cpu_data !== 8'h62) begin n_fail++; $display("FAIL abort_mem0 got %h exp 62", cpu_bus.cpu_data); end
    endtask

    task automatic test_reset_mid;
        press(4'hE);
        press(4'hD);
        press(4'hA);
        pin_n_reset = 1'b0;
        tick(2);
        pin_n_reset = 1'b1;
        tick(2);
        n_checks++; if (load_addr !== exp_reset_addr) begin n_fail++; $display("FAIL mid_addr got %h exp %h", load_addr, exp_reset_addr); end
        n_checks++; if (cpu_bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold got %b exp 1", cpu_bus.cpu_hold); end
        for (int a = 0; a < 16; a++) begin
            cpu_bus.cpu_addr = 4'(a);
            #1;
            n_checks++;
            if (cpu_bus.cpu_data !== exp_img[a]) begin
                n_fail++; $display("FAIL mid_mem[%0d] got %h exp %h", a, cpu_bus.cpu_data, exp_img[a]);
            end
        end
    endtask

    initial begin
        pin_n_reset      = 1'b0;
        pin_switch       = 4'h0;
        pin_n_write      = 1'b1;
        pin_run          = 1'b0;
        cpu_bus.cpu_addr = 4'h0;
        for (int a = 0; a < 16; a++) exp_img[a] = 8'h00;
`ifdef PROG_RAM_PRELOAD_EN
        exp_img[0] = 8'hBC; exp_img[1] = 8'h43; exp_img[2] = 8'h90; exp_img[3] = 8'h86;
        exp_img[4] = 8'hA0; exp_img[5] = 8'h1C; exp_img[6] = 8'h90;
        exp_reset_addr = 4'd7;
`else
        exp_reset_addr = 4'd0;
`endif
        test_reset();
`ifndef PROG_RAM_PRELOAD_EN
        test_basic_entry();
        test_bounce();
        test_wrap();
        test_run_abort();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
